multi_port_dispatch_queue: RTL

- Parametrised in-order dispatch queue between rename/decode and the issue queues.
- Accepts up to WRITE_WIDTH renamed micro-ops per cycle, compacting sparse valid lanes, and presents up to READ_WIDTH oldest entries to dispatch.
- Tracks per-entry source-operand readiness by snooping WB_WIDTH writeback ports; this includes entries being written in the same cycle.
- Successor to the fixed-width queue: adds independent widths, lane compaction, prefix-ordered dequeue, correct wakeup indexing and a free-count output.

---
 rtl/multi_port_dispatch_queue_pkg.sv | 19 +
 rtl/dq_lane_compactor.sv | 26 ++
 rtl/multi_port_dispatch_queue.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/multi_port_dispatch_queue_pkg.sv
// Shared scheduler types: dispatch-queue entry layout and physical register tag width.
`ifndef PHY_REG_NUM
`define PHY_REG_NUM 64
`endif

package multi_port_dispatch_queue_pkg;

    localparam int DQ_PREG_W    = $clog2(`PHY_REG_NUM);
    localparam int DQ_PAYLOAD_W = 16;

    typedef struct packed {
        logic [DQ_PREG_W-1:0]    src0;
        logic [DQ_PREG_W-1:0]    src1;
        logic                    src0_ready;
        logic                    src1_ready;
        logic [DQ_PAYLOAD_W-1:0] payload;
    } dq_entry_t;

endpackage

// File: rtl/dq_lane_compactor.sv
// Lane compactor: maps sparse lane valids to dense slot offsets and a total count.
// Latency: combinational. Backpressure: none, pure function of lane_valid.
// Also used by the issue queues.
module dq_lane_compactor #(
    parameter int WIDTH = 4,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0]            lane_valid,
    output logic [WIDTH-1:0][CNT_W-1:0] slot_off,
    output logic [CNT_W-1:0]            valid_cnt
);

    logic [CNT_W-1:0] acc;

    // Each lane's offset is the number of valid lanes below it.
    always_comb begin
        acc      = '0;
        slot_off = '0;
        for (int i = 0; i < WIDTH; i++) begin
            slot_off[i] = acc;
            acc         = acc + CNT_W'(lane_valid[i]);
        end
        valid_cnt = acc;
    end

endmodule

// File: rtl/multi_port_dispatch_queue.sv
// In-order dispatch queue: compacted multi-lane enqueue, prefix-ordered multi-lane dequeue, wb wakeup.
// Latency: 1 cycle enqueue-to-read, 1 cycle wakeup (0 on read lanes with DQ_WB_READ_BYPASS_EN).
// Backpressure: write_ready_o drops when fewer than WRITE_WIDTH slots free; dropped writes must be held.
module multi_port_dispatch_queue
    import multi_port_dispatch_queue_pkg::*;
#(
    parameter int QUEUE_DEPTH = 16,
    parameter int WRITE_WIDTH = 4,
    parameter int READ_WIDTH  = 4,
    parameter int WB_WIDTH    = 4,
    parameter int PREG_W      = DQ_PREG_W
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  flush_i,
    input  logic      [WRITE_WIDTH-1:0]           write_valid_i,
    input  dq_entry_t [WRITE_WIDTH-1:0]           write_data_i,
    output logic                                  write_ready_o,
    output logic      [READ_WIDTH-1:0]            read_valid_o,
    output dq_entry_t [READ_WIDTH-1:0]            read_data_o,
    input  logic      [READ_WIDTH-1:0]            read_ready_i,
    input  logic      [WB_WIDTH-1:0]              wb_valid_i,
    input  logic      [WB_WIDTH-1:0][PREG_W-1:0]  wb_pdest_i,
    output logic      [$clog2(QUEUE_DEPTH+1)-1:0] free_cnt_o
);

    localparam int PTR_W = $clog2(QUEUE_DEPTH);
    localparam int CNT_W = $clog2(QUEUE_DEPTH + 1);
    localparam int WC_W  = $clog2(WRITE_WIDTH + 1);
    localparam int RC_W  = $clog2(READ_WIDTH + 1);

    dq_entry_t mem_q [QUEUE_DEPTH];
    logic [PTR_W-1:0] head_q, tail_q;
    logic [CNT_W-1:0] cnt_q, free_q, cnt_n;

    logic [WRITE_WIDTH-1:0][WC_W-1:0] wr_off;
    logic [WC_W-1:0]                  wr_cnt_raw, wr_cnt;
    logic                             wr_en;
    logic [RC_W-1:0]                  rd_cnt;
    logic                             rd_run;
    logic [PTR_W-1:0]                 rd_idx;

    logic [QUEUE_DEPTH-1:0]  st_hit0, st_hit1;
    logic [WRITE_WIDTH-1:0]  wr_hit0, wr_hit1;
    dq_entry_t [WRITE_WIDTH-1:0] wr_woken;

    // free_q always mirrors QUEUE_DEPTH - cnt_q, so readiness is purely state-based.
    assign write_ready_o = free_q >= CNT_W'(WRITE_WIDTH);
    assign free_cnt_o    = free_q;
    assign wr_en         = write_ready_o & ~flush_i;
    assign wr_cnt        = wr_en ? wr_cnt_raw : '0;
    assign cnt_n         = cnt_q + CNT_W'(wr_cnt) - CNT_W'(rd_cnt);

    dq_lane_compactor #(
        .WIDTH (WRITE_WIDTH),
        .CNT_W (WC_W)
    ) u_compactor (
        .lane_valid (write_valid_i),
        .slot_off   (wr_off),
        .valid_cnt  (wr_cnt_raw)
    );

    for (genvar e = 0; e < QUEUE_DEPTH; e++) begin : g_st_wake
        logic [WB_WIDTH-1:0] m0, m1;
        for (genvar j = 0; j < WB_WIDTH; j++) begin : g_wb
            assign m0[j] = wb_valid_i[j] && (mem_q[e].src0 == wb_pdest_i[j]);
            assign m1[j] = wb_valid_i[j] && (mem_q[e].src1 == wb_pdest_i[j]);
        end
        assign st_hit0[e] = |m0;
        assign st_hit1[e] = |m1;
    end

    // Incoming lanes see the same writeback match so a same-cycle wakeup is not lost.
    for (genvar w = 0; w < WRITE_WIDTH; w++) begin : g_wr_wake
        logic [WB_WIDTH-1:0] m0, m1;
        for (genvar j = 0; j < WB_WIDTH; j++) begin : g_wb
            assign m0[j] = wb_valid_i[j] && (write_data_i[w].src0 == wb_pdest_i[j]);
            assign m1[j] = wb_valid_i[j] && (write_data_i[w].src1 == wb_pdest_i[j]);
        end
        assign wr_hit0[w] = |m0;
        assign wr_hit1[w] = |m1;
    end

    always_comb begin
        wr_woken = write_data_i;
        for (int w = 0; w < WRITE_WIDTH; w++) begin
            wr_woken[w].src0_ready = write_data_i[w].src0_ready | wr_hit0[w];
            wr_woken[w].src1_ready = write_data_i[w].src1_ready | wr_hit1[w];
        end
    end

    for (genvar i = 0; i < READ_WIDTH; i++) begin : g_rd_vld
        assign read_valid_o[i] = cnt_q > CNT_W'(i);
    end

    // Only the leading run of accepted lanes is consumed; a gap stops dequeue.
    always_comb begin
        rd_cnt = '0;
        rd_run = 1'b1;
        for (int i = 0; i < READ_WIDTH; i++) begin
            rd_run = rd_run & read_ready_i[i] & read_valid_o[i];
            rd_cnt = rd_cnt + RC_W'(rd_run);
        end
    end

    always_comb begin
        read_data_o = '0;
        rd_idx      = '0;
        for (int i = 0; i < READ_WIDTH; i++) begin
            rd_idx         = head_q + PTR_W'(i);
            read_data_o[i] = mem_q[rd_idx];
`ifdef DQ_WB_READ_BYPASS_EN
            read_data_o[i].src0_ready = mem_q[rd_idx].src0_ready | st_hit0[rd_idx];
            read_data_o[i].src1_ready = mem_q[rd_idx].src1_ready | st_hit1[rd_idx];
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= '0;
            free_q <= CNT_W'(QUEUE_DEPTH);
            for (int e = 0; e < QUEUE_DEPTH; e++) begin
                mem_q[e] <= '0;
            end
        end else begin
            for (int e = 0; e < QUEUE_DEPTH; e++) begin
                if (st_hit0[e]) mem_q[e].src0_ready <= 1'b1;
                if (st_hit1[e]) mem_q[e].src1_ready <= 1'b1;
            end
            if (flush_i) begin
                head_q <= '0;
                tail_q <= '0;
                cnt_q  <= '0;
                free_q <= CNT_W'(QUEUE_DEPTH);
            end else begin
                // Written slots are free, so a full-entry write safely follows the wakeup updates.
                for (int w = 0; w < WRITE_WIDTH; w++) begin
                    if (wr_en && write_valid_i[w]) begin
                        mem_q[tail_q + PTR_W'(wr_off[w])] <= wr_woken[w];
                    end
                end
                head_q <= head_q + PTR_W'(rd_cnt);
                tail_q <= tail_q + PTR_W'(wr_cnt);
                cnt_q  <= cnt_n;
                free_q <= CNT_W'(QUEUE_DEPTH) - cnt_n;
            end
        end
    end

endmodule
